dither_ed_multi: RTL and testbench
==================================

Name: dither_ed_multi

Overview:
- Parametrised N-channel colour-depth reducer for the VGA serial display pixel path. It sits between the framebuffer colour fetch and the VGA DAC pins.
- Reduces each channel from IN_W to OUT_W significant bits. Three selectable modes: truncation, threshold rounding, and 1-D horizontal error diffusion with a per-channel error register carried along the scanline.
- Output is left-aligned in IN_W bits with zero low bits, registered, with a one-cycle visible flag delay.

Parameters:
- IN_W, 8, input bits per channel.
- OUT_W, 4, retained bits per channel; D = IN_W-OUT_W, must be >= 1.
- N_CH, 3, number of colour channels.
- THRESHOLD, 4, rounding threshold on the D low bits in threshold mode; must be < 2^D.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active-low.
- mode  in  2  0 = truncate, 1 = threshold, 2 = error diffusion, 3 = reserved (behaves as 0).
- visible  in  1  pixel inside active area.
- color_in  in  N_CH*IN_W  channel k at bits [k*IN_W +: IN_W].
- color_out  out  N_CH*IN_W  dithered channels, same packing; low D bits always 0.
- visible_o  out  1  visible delayed one cycle.

Behaviour:
- Reset: while rst_n=0 at a clk edge, color_out=0, visible_o=0, and all error registers are 0. Reset mid-line discards the accumulated error. The first pixel after reset is processed with err=0.
- Latency: exactly 1 cycle. color_out and visible_o at edge n+1 reflect color_in, visible and mode sampled at edge n.
- Not visible: color_out registers 0, and every error register is cleared to 0, so error never crosses a line or blanking.
- Per channel, definitions: x = input value, q_max = 2^OUT_W-1, lo = x[D-1:0], hi = x[IN_W-1:D].
- Mode 0 (truncate): q = hi.
- Mode 1 (threshold): q = hi+1 if lo >= THRESHOLD and hi != q_max; otherwise q = hi (saturates, no wrap).
- Mode 2 (diffusion), datapath: signed sum s = x + err, width IN_W+2.
- Mode 2, quantise: q = (s + 2^(D-1)) >> D (arithmetic), clamped to [0, q_max].
- Mode 2, error: err_next = s - q*2^D, clamped to signed D+1 bits [-2^D, 2^D-1]. err <= err_next on each visible cycle.
- Modes 0/1/3: error registers are cleared to 0 each cycle. A switch into mode 2 starts from err=0.
- Output: color_out channel = {q, D'b0}.
- Channels are fully independent: no cross-channel error, no vertical diffusion.
- Boundary cases:
  - s negative clamps q to 0.
  - s above the range clamps q to q_max, and err saturates at 2^D-1 rather than growing.
  - x=0 with err=0 yields 0 forever.
- Simultaneous rst_n=0 and visible=1: reset wins.
- No combinational path from inputs to outputs.

Decomposition:
- Package dither_pkg:
  - mode enum: MODE_TRUNC=0, MODE_THRESH=1, MODE_ED=2.
  - Helper function for saturating clamp.
  - Localparam calc for D and error width.
- Sub-module dither_channel:
  - One channel's quantiser plus its error register.
  - Instantiated N_CH times via generate.
- The top level holds only the visible_o register and port packing.

Test Plan (defaults IN_W=8, OUT_W=4, N_CH=3, THRESHOLD=4):
- Mode 0, visible=1, channels {0x37,0xF9,0x0F} -> next cycle color_out {0x30,0xF0,0x00}, visible_o=1.
- Mode 1, channels {0x34,0x33,0xF8} -> {0x40,0x30,0xF0} (third channel saturates, no wrap to 0x00).
- Mode 2, constant 0x08 on all channels for 6 visible cycles -> outputs alternate 0x10,0x00,0x10,0x00,0x10,0x00; mean equals input.
- Mode 2, constant 0xFF for 8 cycles -> output 0xF0 every cycle, and internal err holds 15 (no overflow).
- Mode 2 line-boundary check:
  - Drive 0x08 for 1 cycle -> output 0x10.
  - Drop visible for 1 cycle -> output 0x00, visible_o=0.
  - Drive 0x08 again -> 0x10 (error cleared, not 0x00).
- Mid-line rst_n=0 for 1 cycle during a 0x08 stream in mode 2 -> output 0 during reset; first post-reset pixel yields 0x10.

Source files
------------

// File: rtl/dither_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dither_pkg : shared types and helpers for the colour-depth reducer
// Rev 1.0
// ---------------------------------------------------------------------------
package dither_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'd0,
    MODE_THRESH = 2'd1,
    MODE_ED     = 2'd2
  } mode_e;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_OUT_W = 4;

  function automatic int dither_d(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

  function automatic int dither_err_w(input int in_w, input int out_w);
    return dither_d(in_w, out_w) + 1;
  endfunction

  function automatic int sat_clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dither_channel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dither_channel : one channel's quantiser and horizontal error register
// Rev 1.0
// ---------------------------------------------------------------------------
module dither_channel
  import dither_pkg::*;
#(
  parameter int IN_W      = DEF_IN_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int THRESHOLD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      mode_i,
  input  logic            visible_i,
  input  logic [IN_W-1:0] x_i,
  output logic [IN_W-1:0] y_o
);

  localparam int D     = dither_d(IN_W, OUT_W);
  localparam int EW    = dither_err_w(IN_W, OUT_W);
  localparam int SW    = IN_W + 2;
  localparam int Q_MAX = (2 ** OUT_W) - 1;
  localparam logic signed [SW-1:0] HALF = SW'(1) << (D - 1);

  logic [OUT_W-1:0]     hi;
  logic [D-1:0]         lo;
  logic [OUT_W-1:0]     y_q, y_d;
  logic signed [EW-1:0] err_q, err_d;
  logic signed [SW-1:0] s, qs, e_full;
  logic [OUT_W-1:0]     q_ed;
  logic signed [EW-1:0] err_ed;

  assign hi = x_i[IN_W-1:D];
  assign lo = x_i[D-1:0];

  // Diffusion datapath is wide enough that s, s+half and the residual never wrap.
  assign s      = $signed({2'b00, x_i}) + SW'(err_q);
  assign qs     = (s + HALF) >>> D;
  assign q_ed   = OUT_W'(sat_clamp(int'(qs), 0, Q_MAX));
  assign e_full = s - $signed(SW'(q_ed) << D);
  assign err_ed = EW'(sat_clamp(int'(e_full), -(2 ** D), (2 ** D) - 1));

  always_comb begin
    y_d   = '0;
    err_d = '0;
    if (visible_i) begin
      case (mode_i)
        MODE_THRESH: begin
          if ((lo >= D'(THRESHOLD)) && (hi != OUT_W'(Q_MAX))) y_d = hi + OUT_W'(1);
          else                                                y_d = hi;
        end
        MODE_ED: begin
          y_d   = q_ed;
          err_d = err_ed;
        end
        default: y_d = hi;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q   <= '0;
      err_q <= '0;
    end else begin
      y_q   <= y_d;
      err_q <= err_d;
    end
  end

  assign y_o = {y_q, {D{1'b0}}};

endmodule
`default_nettype wire

// File: rtl/dither_ed_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dither_ed_multi : N-channel colour-depth reducer with error diffusion
// Rev 1.0
// ---------------------------------------------------------------------------
module dither_ed_multi
  import dither_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 4,
  parameter int N_CH      = 3,
  parameter int THRESHOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 visible,
  input  logic [N_CH*IN_W-1:0] color_in,
  output logic [N_CH*IN_W-1:0] color_out,
  output logic                 visible_o
);

  logic visible_q;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    dither_channel #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .THRESHOLD (THRESHOLD)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode_i    (mode),
      .visible_i (visible),
      .x_i       (color_in[k*IN_W +: IN_W]),
      .y_o       (color_out[k*IN_W +: IN_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) visible_q <= 1'b0;
    else        visible_q <= visible;
  end

  assign visible_o = visible_q;

endmodule
`default_nettype wire

// File: tb/tb_dither_ed_multi.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dither_ed_multi : directed scoreboard bench for dither_ed_multi
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dither_ed_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        visible;
  logic [23:0] color_in;
  logic [23:0] color_out;
  logic        visible_o;

  typedef struct {
    logic [23:0] color;
    logic        vis;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;

  dither_ed_multi #(
    .IN_W(8), .OUT_W(4), .N_CH(3), .THRESHOLD(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .visible   (visible),
    .color_in  (color_in),
    .color_out (color_out),
    .visible_o (visible_o)
  );

  always #5 clk = ~clk;

  // Drive one pixel before the rising edge and queue the response expected after it.
  task automatic step(input string nm, input logic r, input logic [1:0] m, input logic v,
                      input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec,
                      input logic ev);
    exp_t e;
    @(negedge clk);
    rst_n    = r;
    mode     = m;
    visible  = v;
    color_in = {c, b, a};
    e.color  = {ec, eb, ec == ec ? ea : ea};
    e.vis    = ev;
    e.name   = nm;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      total++;
      if (color_out !== cur.color || visible_o !== cur.vis) begin
        bad++;
        $display("FAIL %s: got color=%h vis=%b expected color=%h vis=%b",
                 cur.name, color_out, visible_o, cur.color, cur.vis);
      end
    end
  end

  initial begin
    rst_n = 1'b0; mode = 2'd0; visible = 1'b0; color_in = '0;

    step("reset0",  0, 0, 1, 8'h37, 8'hF9, 8'h0F, 8'h00, 8'h00, 8'h00, 0);
    step("reset1",  0, 2, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 0);

    step("trunc",   1, 0, 1, 8'h37, 8'hF9, 8'h0F, 8'h30, 8'hF0, 8'h00, 1);
    step("mode3",   1, 3, 1, 8'h37, 8'hF9, 8'h0F, 8'h30, 8'hF0, 8'h00, 1);
    step("thresh",  1, 1, 1, 8'h34, 8'h33, 8'hF8, 8'h40, 8'h30, 8'hF0, 1);
    step("thr_blank", 1, 1, 0, 8'h34, 8'h33, 8'hF8, 8'h00, 8'h00, 8'h00, 0);

    for (int i = 0; i < 6; i++)
      step("ed_half", 1, 2, 1, 8'h08, 8'h08, 8'h08,
           (i % 2 == 0) ? 8'h10 : 8'h00, (i % 2 == 0) ? 8'h10 : 8'h00,
           (i % 2 == 0) ? 8'h10 : 8'h00, 1);

    for (int i = 0; i < 8; i++)
      step("ed_sat", 1, 2, 1, 8'hFF, 8'hFF, 8'hFF, 8'hF0, 8'hF0, 8'hF0, 1);
    // Saturated error of +15 carried into black, then -1 residual.
    step("ed_sat_err0", 1, 2, 1, 8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h10, 1);
    step("ed_sat_err1", 1, 2, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    step("mode_clr",  1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    step("line_a",    1, 2, 1, 8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 1);
    step("line_blank",1, 2, 0, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    step("line_b",    1, 2, 1, 8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 1);
    step("line_c",    1, 2, 1, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 1);
    step("line_d",    1, 2, 1, 8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 1);

    step("mid_rst",   0, 2, 1, 8'h08, 8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 0);
    step("post_rst",  1, 2, 1, 8'h08, 8'h08, 8'h08, 8'h10, 8'h10, 8'h10, 1);

    // Independent channels from err=-8: negative sum clamps to zero.
    step("neg_a",     1, 2, 1, 8'h03, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    step("neg_b",     1, 2, 1, 8'h0B, 8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 1);
    step("neg_c",     1, 2, 1, 8'h0B, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 1);

    step("idle",      1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    repeat (4) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got pending=%0d expected pending=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
